// File: rtl/addr_demux8.sv
// ---------------------------------------------------------------------------
// addr_demux8
//
// Eight-bit addressable output register with a frame tracker. Each write
// steers one data bit (d ^ pol) into one register bit. The bit index comes
// either from the {c,b,a} select pins (inc_=1) or from an internal
// auto-increment counter (inc_=0). A written-bits mask tracks which indices
// have been written since the last completed frame. When all eight indices
// have been written, rdy pulses high for one cycle and the mask restarts.
//
// Optional feature macro: ADDR_DEMUX8_LOAD_EN
//   When defined, the ports pd[7:0] and ld_ are added. A parallel load
//   (ld_=0) replaces the whole register with pd ^ {8{pol}}, resets the
//   counter and the mask, and counts as a completed frame. A load takes
//   priority over a write on the same edge.
//
// Ports
//   clk    rising-edge clock
//   clr_   synchronous active-low clear of register, mask, counter, rdy
//   d      data bit to write
//   a,b,c  explicit bit index {c,b,a} (a = LSB), used when inc_=1
//   pol    polarity; the stored bit is d ^ pol
//   me_    active-low write enable
//   inc_   active-low auto-increment select (0 = use internal counter)
//   oe_    active-low output enable for q
//   q      register contents, high impedance when oe_=1
//   cnt    internal auto-increment counter
//   rdy    registered one-cycle frame-complete pulse
//   pd     parallel load data      (ADDR_DEMUX8_LOAD_EN only)
//   ld_    active-low parallel load (ADDR_DEMUX8_LOAD_EN only)
// ---------------------------------------------------------------------------
module addr_demux8 (
    input  logic       clk,
    input  logic       clr_,
    input  logic       d,
    input  logic       a,
    input  logic       b,
    input  logic       c,
    input  logic       pol,
    input  logic       me_,
    input  logic       inc_,
    input  logic       oe_,
`ifdef ADDR_DEMUX8_LOAD_EN
    input  logic [7:0] pd,
    input  logic       ld_,
`endif
    output logic [7:0] q,
    output logic [2:0] cnt,
    output logic       rdy
);

    // Architectural state
    logic [7:0] data_reg;
    logic [7:0] data_next;
    logic [7:0] mask_reg;
    logic [7:0] mask_next;
    logic [2:0] ctr_reg;
    logic [2:0] ctr_next;
    logic       rdy_reg;
    logic       rdy_next;

    // Parallel load path; tied off when the feature is not built in
    logic       load_active;
    logic [7:0] load_word;

`ifdef ADDR_DEMUX8_LOAD_EN
    assign load_active = ~ld_;
    assign load_word   = pd ^ {8{pol}};
`else
    assign load_active = 1'b0;
    assign load_word   = 8'h00;
`endif

    // Bit index for a write: counter in auto mode, select pins otherwise
    logic [2:0] idx;
    assign idx = inc_ ? {c, b, a} : ctr_reg;

    logic       wr_bit;
    assign wr_bit = d ^ pol;

    // Per-bit steering: the addressed bit takes the new value, the others
    // keep their contents. The mask gets the addressed bit set.
    logic [7:0] written_word;
    logic [7:0] mask_merged;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi = gi + 1) begin : g_bit
            assign written_word[gi] = (idx == gi[2:0]) ? wr_bit : data_reg[gi];
            assign mask_merged[gi]  = (idx == gi[2:0]) | mask_reg[gi];
        end
    endgenerate

    // Next-state selection: load, then write, then hold. Clear is applied
    // in the register process since it overrides everything.
    always_comb begin
        data_next = data_reg;
        mask_next = mask_reg;
        ctr_next  = ctr_reg;
        rdy_next  = 1'b0;

        if (load_active) begin
            data_next = load_word;
            mask_next = 8'h00;
            ctr_next  = 3'd0;
            rdy_next  = 1'b1;
        end else if (!me_) begin
            data_next = written_word;
            if (!inc_) begin
                ctr_next = ctr_reg + 3'd1;  // wraps 7 -> 0 naturally
            end
            // Rewriting an index already in the mask leaves the mask
            // unchanged, so it cannot complete a frame by itself.
            if (mask_merged == 8'hFF) begin
                rdy_next  = 1'b1;
                mask_next = 8'h00;
            end else begin
                mask_next = mask_merged;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!clr_) begin
            data_reg <= 8'h00;
            mask_reg <= 8'h00;
            ctr_reg  <= 3'd0;
            rdy_reg  <= 1'b0;
        end else begin
            data_reg <= data_next;
            mask_reg <= mask_next;
            ctr_reg  <= ctr_next;
            rdy_reg  <= rdy_next;
        end
    end

    // Output enable only gates the pins; it never touches state.
    assign q   = oe_ ? 8'bzzzz_zzzz : data_reg;
    assign cnt = ctr_reg;
    assign rdy = rdy_reg;

endmodule

// File: tb/tb_addr_demux8.sv
// ---------------------------------------------------------------------------
// tb_addr_demux8
//
// Directed test of addr_demux8. A behavioural model tracks the register
// bits, the set of distinct indices written in the current frame and the
// counter as plain integers/arrays; a compare process checks q, cnt and rdy
// against it on every falling edge. Hand-computed literal expectations pin
// the model at key points of each scenario.
// ---------------------------------------------------------------------------
module tb_addr_demux8;

    logic       clk = 1'b0;
    logic       clr_ = 1'b0;
    logic       d = 1'b0;
    logic       a = 1'b0;
    logic       b = 1'b0;
    logic       c = 1'b0;
    logic       pol = 1'b0;
    logic       me_ = 1'b1;
    logic       inc_ = 1'b1;
    logic       oe_ = 1'b1;
`ifdef ADDR_DEMUX8_LOAD_EN
    logic [7:0] pd = 8'h00;
    logic       ld_ = 1'b1;
`endif
    logic [7:0] q;
    logic [2:0] cnt;
    logic       rdy;

    int checks = 0;
    int errors = 0;
    bit checking = 1'b0;

    always #5 clk = ~clk;

    addr_demux8 dut (
        .clk  (clk),
        .clr_ (clr_),
        .d    (d),
        .a    (a),
        .b    (b),
        .c    (c),
        .pol  (pol),
        .me_  (me_),
        .inc_ (inc_),
        .oe_  (oe_),
`ifdef ADDR_DEMUX8_LOAD_EN
        .pd   (pd),
        .ld_  (ld_),
`endif
        .q    (q),
        .cnt  (cnt),
        .rdy  (rdy)
    );

    // ---------------- behavioural model ----------------
    int m_bits [8];
    bit m_seen [8];
    int m_nseen = 0;
    int m_ctr = 0;
    int m_rdy = 0;

    function automatic int model_q();
        int v = 0;
        for (int i = 0; i < 8; i++) v += m_bits[i] * (1 << i);
        return v;
    endfunction

    task automatic model_step();
        int ix;
        bit loading;
        loading = 1'b0;
`ifdef ADDR_DEMUX8_LOAD_EN
        loading = (ld_ == 1'b0);
`endif
        if (clr_ == 1'b0) begin
            for (int i = 0; i < 8; i++) begin m_bits[i] = 0; m_seen[i] = 0; end
            m_nseen = 0; m_ctr = 0; m_rdy = 0;
        end else if (loading) begin
`ifdef ADDR_DEMUX8_LOAD_EN
            for (int i = 0; i < 8; i++) m_bits[i] = (pd[i] != pol) ? 1 : 0;
`endif
            for (int i = 0; i < 8; i++) m_seen[i] = 0;
            m_nseen = 0; m_ctr = 0; m_rdy = 1;
        end else if (me_ == 1'b0) begin
            ix = inc_ ? (c * 4 + b * 2 + a) : m_ctr;
            m_bits[ix] = (d != pol) ? 1 : 0;
            if (!m_seen[ix]) begin m_seen[ix] = 1; m_nseen++; end
            if (m_nseen == 8) begin
                for (int i = 0; i < 8; i++) m_seen[i] = 0;
                m_nseen = 0; m_rdy = 1;
            end else begin
                m_rdy = 0;
            end
            if (!inc_) m_ctr = (m_ctr + 1) % 8;
        end else begin
            m_rdy = 0;
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin m_bits[i] = 0; m_seen[i] = 0; end
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (checking) begin
            checks++;
            if (oe_) begin
                // Released bus: a 4-state simulator shows z, a 2-state one 0.
                if (!(q === 8'bzzzz_zzzz || q === 8'h00)) begin
                    errors++;
                    $display("FAIL cyc_q_tristate: got %h, expected zz", q);
                end
            end else if (q !== model_q()) begin
                errors++;
                $display("FAIL cyc_q: got %h, expected %h", q, model_q());
            end
            checks++;
            if (cnt !== m_ctr[2:0]) begin
                errors++;
                $display("FAIL cyc_cnt: got %0d, expected %0d", cnt, m_ctr);
            end
            checks++;
            if (rdy !== m_rdy[0]) begin
                errors++;
                $display("FAIL cyc_rdy: got %0b, expected %0b", rdy, m_rdy[0]);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic lit(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic dd, input logic [2:0] ix, input logic p, input logic inc);
        me_ = 1'b0; d = dd; {c, b, a} = ix; pol = p; inc_ = inc;
        tick();
        me_ = 1'b1;
        $display("write d=%0b idx=%0d pol=%0b inc_=%0b -> q=%h cnt=%0d rdy=%0b",
                 dd, ix, p, inc, q, cnt, rdy);
    endtask

    logic [7:0] pat;
    logic [7:0] exp_q;

    initial begin
        // Tristate and reset
        tick(); tick();
        checking = 1'b1;
        clr_ = 1'b1;
        tick();
        lit("rst_cnt", {5'd0, cnt}, 8'h00);
        lit("rst_rdy", {7'd0, rdy}, 8'h00);
        oe_ = 1'b0;
        #1;
        lit("rst_q", q, 8'h00);

        // Explicit addressing, only the written bit rises each time
        exp_q = 8'h00;
        for (int i = 0; i < 8; i++) begin
            wr(1'b1, i[2:0], 1'b0, 1'b1);
            exp_q[i] = 1'b1;
            lit("expl_q", q, exp_q);
            lit("expl_rdy", {7'd0, rdy}, (i == 7) ? 8'h01 : 8'h00);
        end
        lit("expl_final_q", q, 8'hFF);
        lit("expl_cnt", {5'd0, cnt}, 8'h00);
        tick();
        lit("expl_rdy_drop", {7'd0, rdy}, 8'h00);

        // oe_ is combinational on q
        oe_ = 1'b1;
        #1;
        checks++;
        if (!(q === 8'bzzzz_zzzz || q === 8'h00)) begin
            errors++;
            $display("FAIL oe_tristate: got %h, expected zz", q);
        end
        oe_ = 1'b0;
        #1;
        lit("oe_enable", q, 8'hFF);

        // Polarity and repeated index
        wr(1'b1, 3'd3, 1'b1, 1'b1);
        lit("pol_q", q, 8'hF7);
        wr(1'b1, 3'd3, 1'b1, 1'b1);
        lit("repeat_rdy", {7'd0, rdy}, 8'h00);
        for (int i = 0; i < 8; i++) begin
            if (i != 3) wr(1'b1, i[2:0], 1'b1, 1'b1);
        end
        lit("pol_frame_rdy", {7'd0, rdy}, 8'h01);
        lit("pol_frame_q", q, 8'h00);

        // Auto mode, pattern 1,0,1,1,0,0,1,0
        pat = 8'b0100_1101;
        for (int i = 0; i < 8; i++) begin
            wr(pat[i], 3'd0, 1'b0, 1'b0);
            lit("auto_cnt", {5'd0, cnt}, 8'((i + 1) % 8));
        end
        lit("auto_q", q, 8'h4D);
        lit("auto_rdy", {7'd0, rdy}, 8'h01);
        for (int i = 0; i < 8; i++) begin
            wr(1'b0, 3'd0, 1'b0, 1'b0);
            lit("auto2_rdy", {7'd0, rdy}, (i == 7) ? 8'h01 : 8'h00);
        end

        // Clear mid-frame discards the mask
        for (int i = 0; i < 5; i++) wr(1'b1, 3'd0, 1'b0, 1'b0);
        clr_ = 1'b0;
        tick();
        clr_ = 1'b1;
        lit("clr_q", q, 8'h00);
        lit("clr_cnt", {5'd0, cnt}, 8'h00);
        for (int i = 0; i < 8; i++) begin
            wr(1'b1, 3'd0, 1'b0, 1'b0);
            lit("post_clr_rdy", {7'd0, rdy}, (i == 7) ? 8'h01 : 8'h00);
        end

        // Clear on the same edge as the completing write wins
        for (int i = 0; i < 7; i++) wr(1'b1, 3'd0, 1'b0, 1'b0);
        clr_ = 1'b0;
        wr(1'b1, 3'd0, 1'b0, 1'b0);
        clr_ = 1'b1;
        lit("clr_wins_rdy", {7'd0, rdy}, 8'h00);
        lit("clr_wins_q", q, 8'h00);
        lit("clr_wins_cnt", {5'd0, cnt}, 8'h00);

`ifdef ADDR_DEMUX8_LOAD_EN
        // Load beats a simultaneous write
        wr(1'b1, 3'd0, 1'b0, 1'b0);
        ld_ = 1'b0; pd = 8'hA5;
        wr(1'b1, 3'd1, 1'b0, 1'b1);
        ld_ = 1'b1;
        lit("load_q", q, 8'hA5);
        lit("load_cnt", {5'd0, cnt}, 8'h00);
        lit("load_rdy", {7'd0, rdy}, 8'h01);
        tick();
        lit("load_rdy_drop", {7'd0, rdy}, 8'h00);
`endif

        tick();
        checking = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
